signal_framer: RTL and testbench

//  Front-end windowing source for per-frame feature blocks (ZCR, energy, ...).

---
 rtl/signal_framer.sv | 126 ++++++++++++
 tb/tb_signal_framer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_framer.sv
// Circular-buffer framer: emits overlapping WIN_LEN windows (oldest first) every HOP samples.
// Completing sample -> frame_init next cycle -> first window sample the cycle after; input stalls while a window drains.
module signal_framer #(
  parameter int WIN_LEN = 512,
  parameter int HOP     = 256,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_rdy,
  output logic              frame_init,
  output logic [DATA_W-1:0] window_data,
  output logic              window_valid,
  input  logic              window_rdy,
  output logic              window_last,
  output logic [15:0]       frame_idx
);

  localparam int AW = $clog2(WIN_LEN);
  localparam logic [AW:0]   WIN_CNT  = (AW+1)'(WIN_LEN);
  localparam logic [AW:0]   HOP_CNT  = (AW+1)'(HOP);
  localparam logic [AW-1:0] LAST_POS = AW'(WIN_LEN - 1);

  typedef enum logic [1:0] {S_FILL, S_INIT, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     out_cnt_q, out_cnt_d;
  logic [AW:0]       new_cnt_q, new_cnt_d;
  logic              primed_q, primed_d;
  logic [15:0]       frame_idx_q, frame_idx_d;
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] mem [WIN_LEN];

  logic        clr;
  logic        wr_en;
  logic        rd_xfer;
  logic        rd_en;
  logic [AW:0] cnt_inc;

  assign clr          = rst | flush;
  assign sample_rdy   = (state_q == S_FILL);
  assign frame_init   = (state_q == S_INIT);
  assign window_valid = (state_q == S_STREAM);
  assign window_last  = window_valid && (out_cnt_q == LAST_POS);
  assign window_data  = rd_dat_q;
  assign frame_idx    = frame_idx_q;

  assign wr_en   = sample_valid & sample_rdy & ~clr;
  assign rd_xfer = window_valid & window_rdy;
  assign rd_en   = (state_q != S_FILL);
  assign cnt_inc = new_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_cnt_d   = out_cnt_q;
    new_cnt_d   = new_cnt_q;
    primed_d    = primed_q;
    frame_idx_d = frame_idx_q;
    case (state_q)
      S_FILL: begin
        if (wr_en) begin
          wr_ptr_d  = wr_ptr_q + 1'b1;
          new_cnt_d = cnt_inc;
          // First window needs a full buffer, later ones only HOP fresh samples.
          if (cnt_inc == (primed_q ? HOP_CNT : WIN_CNT)) state_d = S_INIT;
        end
      end
      S_INIT: begin
        rd_ptr_d = wr_ptr_q;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (rd_xfer) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          out_cnt_d = out_cnt_q + 1'b1;
          if (window_last) begin
            state_d     = S_FILL;
            new_cnt_d   = '0;
            out_cnt_d   = '0;
            primed_d    = 1'b1;
            frame_idx_d = frame_idx_q + 16'd1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      new_cnt_q   <= '0;
      primed_q    <= 1'b0;
      frame_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_cnt_q   <= out_cnt_d;
      new_cnt_q   <= new_cnt_d;
      primed_q    <= primed_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_data;
  end

  // Reading at the next pointer keeps the output stable on stalls and gap-free on streaming.
  always_ff @(posedge clk) begin
    if (clr) rd_dat_q <= '0;
    else if (rd_en) rd_dat_q <= mem[rd_ptr_d];
  end

endmodule

// File: tb/tb_signal_framer.sv
// Bench for signal_framer: queue-based window model plus directed literal checks;
// small WIN_LEN=8 instances with HOP=1 and HOP=8 run alongside the default build.
module tb_signal_framer;
  localparam int W  = 512;
  localparam int H  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, sample_valid, sample_rdy, frame_init;
  logic        window_valid, window_rdy, window_last;
  logic [15:0] sample_data, window_data, frame_idx;

  logic        rdy_b, fi_b, wv_b, wl_b, rdy_c, fi_c, wv_c, wl_c;
  logic [15:0] sd_b, wd_b, fx_b, sd_c, wd_c, fx_c;

  signal_framer #(.WIN_LEN(W), .HOP(H), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_rdy(sample_rdy), .frame_init(frame_init), .window_data(window_data),
    .window_valid(window_valid), .window_rdy(window_rdy), .window_last(window_last), .frame_idx(frame_idx));

  signal_framer #(.WIN_LEN(8), .HOP(1), .DATA_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0), .sample_data(sd_b), .sample_valid(1'b1),
    .sample_rdy(rdy_b), .frame_init(fi_b), .window_data(wd_b),
    .window_valid(wv_b), .window_rdy(1'b1), .window_last(wl_b), .frame_idx(fx_b));

  signal_framer #(.WIN_LEN(8), .HOP(8), .DATA_W(16)) dut_c (
    .clk(clk), .rst(rst), .flush(1'b0), .sample_data(sd_c), .sample_valid(1'b1),
    .sample_rdy(rdy_c), .frame_init(fi_c), .window_data(wd_c),
    .window_valid(wv_c), .window_rdy(1'b1), .window_last(wl_c), .frame_idx(fx_c));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source for the main instance: ramp value = number of samples accepted so far.
  logic src_en   = 1'b0;
  int   rdy_mode = 0;
  int   seq      = 0;
  initial begin
    bit acc;
    int ph;
    sample_valid = 1'b0;
    sample_data  = '0;
    window_rdy   = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk);
      acc = sample_valid && sample_rdy && !rst && !flush;
      @(posedge clk);
      #1;
      if (acc) seq++;
      sample_data  = 16'(seq);
      sample_valid = src_en;
      case (rdy_mode)
        0: window_rdy = 1'b1;
        1: begin window_rdy = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
        2: window_rdy = 1'($urandom_range(0, 1));
        default: window_rdy = 1'b0;
      endcase
    end
  end

  // Sources for the small instances: always valid, ramp restarts at reset.
  int seq_b = 0;
  int seq_c = 0;
  initial begin
    bit ab, ac, r;
    sd_b = '0;
    sd_c = '0;
    forever begin
      @(negedge clk);
      ab = rdy_b && !rst;
      ac = rdy_c && !rst;
      r  = rst;
      @(posedge clk);
      #1;
      if (r) begin seq_b = 0; seq_c = 0; end
      else begin
        if (ab) seq_b++;
        if (ac) seq_c++;
      end
      sd_b = 16'(seq_b);
      sd_c = 16'(seq_c);
    end
  end

  // Main model: every accepted sample goes into a history; window k, position j = hist[k*H+j].
  int   hist[$];
  int   k = 0, j = 0;
  bit   wait_init = 0, streaming = 0, pv = 0;
  logic [15:0] pd;
  logic        pl;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        hist.delete();
        k = 0; j = 0; wait_init = 0; streaming = 0; pv = 0;
      end else if (wait_init) begin
        check("init_pulse", frame_init, 1);
        check("init_valid", window_valid, 0);
        check("init_rdy", sample_rdy, 0);
        wait_init = 0;
        streaming = 1;
      end else if (streaming) begin
        check("stream_valid", window_valid, 1);
        check("stream_init", frame_init, 0);
        check("stream_rdy", sample_rdy, 0);
        check("stream_data", window_data, 16'(hist[k*H+j]));
        check("stream_last", window_last, (j == W-1));
        check("stream_idx", frame_idx, 16'(k));
        if (pv) begin
          check("stall_data", window_data, pd);
          check("stall_last", window_last, pl);
        end
        if (window_rdy) begin
          pv = 0;
          j++;
          if (j == W) begin j = 0; k++; streaming = 0; end
        end else begin
          pv = 1; pd = window_data; pl = window_last;
        end
      end else begin
        check("fill_init", frame_init, 0);
        check("fill_valid", window_valid, 0);
        check("fill_rdy", sample_rdy, 1);
        check("fill_idx", frame_idx, 16'(k));
        if (sample_valid) begin
          hist.push_back(int'(sample_data));
          if (hist.size() == k*H + W) wait_init = 1;
        end
      end
    end
  end

  // Small instances: window k position j must hold sample k*HOP+j.
  int kb = 0, jb = 0, kc = 0, jc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        kb = 0; jb = 0; kc = 0; jc = 0;
      end else begin
        if (wv_b) begin
          check("b_data", wd_b, 16'(kb + jb));
          check("b_last", wl_b, (jb == 7));
          check("b_idx", fx_b, 16'(kb));
          check("b_rdy", rdy_b, 0);
          jb++;
          if (jb == 8) begin jb = 0; kb++; end
        end
        if (wv_c) begin
          check("c_data", wd_c, 16'(kc*8 + jc));
          check("c_last", wl_c, (jc == 7));
          check("c_idx", fx_c, 16'(kc));
          check("c_rdy", rdy_c, 0);
          jc++;
          if (jc == 8) begin jc = 0; kc++; end
        end
      end
    end
  end

  task automatic wait_sig(input int which, input int budget, output int cyc);
    bit hit;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < budget) begin
      @(negedge clk);
      cyc++;
      case (which)
        0: hit = frame_init;
        1: hit = window_valid;
        default: hit = window_valid && window_last;
      endcase
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_event_%0d: not seen within %0d cycles", which, budget);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s0, t;
    rst = 1'b1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", window_valid, 0);
    check("rst_init", frame_init, 0);
    check("rst_last", window_last, 0);
    check("rst_data", window_data, 0);
    check("rst_idx", frame_idx, 0);
    check("rst_rdy", sample_rdy, 1);

    @(posedge clk); #2 src_en = 1'b1;
    wait_sig(0, 1000, c);
    check("w0_accepted", seq, 512);
    wait_sig(1, 3, c);
    check("w0_first", window_data, 0);
    check("w0_idx", frame_idx, 0);
    wait_sig(2, 600, c);
    check("w0_gapless", c, 511);
    check("w0_last", window_data, 511);

    wait_sig(0, 600, c);
    check("w1_accepted", seq, 768);
    wait_sig(1, 3, c);
    check("w1_first", window_data, 256);
    check("w1_idx", frame_idx, 1);
    @(posedge clk); #2 rdy_mode = 1;
    wait_sig(2, 3000, c);
    check("w1_last", window_data, 767);

    @(posedge clk); #2 rdy_mode = 2;
    wait_sig(0, 3000, c);
    wait_sig(1, 3, c);
    check("w2_first", window_data, 512);
    check("w2_idx", frame_idx, 2);
    wait_sig(2, 3000, c);
    check("w2_last", window_data, 1023);

    @(posedge clk); #2 rdy_mode = 0;
    wait_sig(0, 600, c);
    wait_sig(1, 3, c);
    t = 0;
    c = 0;
    while (t < 100 && c < 1000) begin
      if (window_valid && window_rdy) t++;
      if (t < 100) begin @(negedge clk); c++; end
    end
    @(posedge clk); #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    check("flush_valid", window_valid, 0);
    check("flush_idx", frame_idx, 0);

    repeat (300) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
    @(negedge clk);
    s0 = seq;
    wait_sig(0, 1000, c);
    check("refill_count", seq - s0, 512);

    for (int m = 0; m < 20; m++) begin
      if (m > 0) wait_sig(0, 1200, c);
      wait_sig(1, 3, c);
      check("ramp_first", window_data, 16'(s0 + 256*m));
      check("ramp_idx", frame_idx, 16'(m));
    end
    wait_sig(2, 600, c);
    check("ramp_last", window_data, 16'(s0 + 256*19 + 511));

    check("b_progress", (kb >= 20), 1);
    check("c_progress", (kc >= 20), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
